// File: rtl/oc8051_cxrom_arb_pkg.sv
// ============================================================================
// oc8051_cxrom_arb_pkg : shared types and constants for the code-ROM arbiter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package oc8051_cxrom_arb_pkg;

  localparam int ROM_SIZE_DEFAULT = 10000;
  localparam int ID_W             = 1;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/oc8051_rr_pick2.sv
// ============================================================================
// oc8051_rr_pick2 : two-way round-robin pick, favours the requester not last granted
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oc8051_rr_pick2
  import oc8051_cxrom_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_gnt,
  output req_id_t    gnt_id,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    gnt_id = req_id_t'(0);
    if (req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else if (req[1]) begin
      gnt_id = req_id_t'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/oc8051_cxrom_arb.sv
// ============================================================================
// oc8051_cxrom_arb : two-requester arbiter in front of a combinational code ROM
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module oc8051_cxrom_arb
  import oc8051_cxrom_arb_pkg::*;
#(
  parameter int ROM_SIZE = ROM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic [15:0] r0_addr,
  output logic        r0_ack,
  output logic [31:0] r0_data,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [15:0] r1_addr,
  output logic        r1_ack,
  output logic [31:0] r1_data,
  output logic        r1_err,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data
);

  localparam logic [31:0] LAST_OK = 32'(ROM_SIZE - 4);

  state_t     state;
  state_t     state_next;
  req_id_t    gnt_q;
  req_id_t    last_gnt;
  req_id_t    pick_id;
  logic       pick_valid;
  logic [1:0] pick_req;
  logic       grant;
  logic       capture;
  logic       addr_err;

  oc8051_rr_pick2 u_pick (
    .req      (pick_req),
    .last_gnt (last_gnt),
    .gnt_id   (pick_id),
    .valid    (pick_valid)
  );

  // A 4-byte fetch starting above 0xFFFC wraps past the 16-bit space.
  assign addr_err = ({16'd0, rom_addr} > LAST_OK) || (rom_addr > 16'hFFFC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pick_req   = 2'b00;
    grant      = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        pick_req = {r1_req, r0_req};
        if (pick_valid) begin
          grant      = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        // The acked requester still holds req from the finished transaction.
        pick_req = (gnt_q == req_id_t'(1)) ? {1'b0, r0_req} : {r1_req, 1'b0};
        if (pick_valid) begin
          grant      = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr <= 16'd0;
      gnt_q    <= req_id_t'(0);
      last_gnt <= req_id_t'(1);
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_data  <= 32'd0;
      r1_data  <= 32'd0;
      r0_err   <= 1'b0;
      r1_err   <= 1'b0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      if (grant) begin
        rom_addr <= (pick_id == req_id_t'(1)) ? r1_addr : r0_addr;
        gnt_q    <= pick_id;
        last_gnt <= pick_id;
      end
      if (capture) begin
        if (gnt_q == req_id_t'(1)) begin
          r1_data <= addr_err ? 32'd0 : rom_data;
          r1_err  <= addr_err;
          r1_ack  <= 1'b1;
        end else begin
          r0_data <= addr_err ? 32'd0 : rom_data;
          r0_err  <= addr_err;
          r0_ack  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oc8051_cxrom_arb.sv
// ============================================================================
// tb_oc8051_cxrom_arb : directed self-checking bench for the code-ROM arbiter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_oc8051_cxrom_arb;

  logic        clk;
  logic        rst;
  logic        r0_req;
  logic [15:0] r0_addr;
  logic        r0_ack;
  logic [31:0] r0_data;
  logic        r0_err;
  logic        r1_req;
  logic [15:0] r1_addr;
  logic        r1_ack;
  logic [31:0] r1_data;
  logic        r1_err;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;

  int n_vec;
  int n_err;

  oc8051_cxrom_arb #(.ROM_SIZE(10000)) dut (
    .clk      (clk),
    .rst      (rst),
    .r0_req   (r0_req),
    .r0_addr  (r0_addr),
    .r0_ack   (r0_ack),
    .r0_data  (r0_data),
    .r0_err   (r0_err),
    .r1_req   (r1_req),
    .r1_addr  (r1_addr),
    .r1_ack   (r1_ack),
    .r1_data  (r1_data),
    .r1_err   (r1_err),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: bytes 0x10..0x13 are 11,22,33,44; elsewhere lo^hi^A5.
  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h0010: rom_byte = 8'h11;
      16'h0011: rom_byte = 8'h22;
      16'h0012: rom_byte = 8'h33;
      16'h0013: rom_byte = 8'h44;
      default:  rom_byte = a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  assign rom_data = {rom_byte(rom_addr + 16'd3), rom_byte(rom_addr + 16'd2),
                     rom_byte(rom_addr + 16'd1), rom_byte(rom_addr)};

  // Single transaction from an idle start; cyc = negedges until ack (-1 on timeout).
  task automatic do_txn(input bit id, input logic [15:0] addr,
                        output int cyc, output logic [31:0] d, output logic e);
    int i;
    @(negedge clk);
    if (id) begin r1_req = 1'b1; r1_addr = addr; end
    else    begin r0_req = 1'b1; r0_addr = addr; end
    cyc = -1; d = 32'hX; e = 1'bX; i = 0;
    while (cyc < 0 && i < 10) begin
      @(posedge clk); @(negedge clk); i++;
      if (id ? r1_ack : r0_ack) begin
        cyc = i;
        d   = id ? r1_data : r0_data;
        e   = id ? r1_err : r0_err;
      end
    end
    if (id) r1_req = 1'b0; else r0_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0; r0_addr = 16'h0; r1_addr = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({r0_ack, r1_ack} !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b expected 00", {r0_ack, r1_ack}); end
    n_vec++; if ({r0_data, r1_data} !== 64'd0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {r0_data, r1_data}); end
    n_vec++; if ({r0_err, r1_err} !== 2'b00) begin n_err++; $display("FAIL reset_err: got %b expected 00", {r0_err, r1_err}); end
    n_vec++; if (rom_addr !== 16'h0) begin n_err++; $display("FAIL reset_rom_addr: got %h expected 0000", rom_addr); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single;
    int cyc; logic [31:0] d; logic e;
    do_txn(1'b0, 16'h0010, cyc, d, e);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL single_latency: got %0d expected 2", cyc); end
    n_vec++; if (d !== 32'h44332211) begin n_err++; $display("FAIL single_data: got %h expected 44332211", d); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL single_err: got %b expected 0", e); end
    @(negedge clk);
    n_vec++; if (r0_ack !== 1'b0) begin n_err++; $display("FAIL single_ack_pulse: got %b expected 0", r0_ack); end
  endtask

  // Both requesters raised together; returns ack times for each.
  task automatic run_tie(output int t0, output int t1, output logic [31:0] d0, output logic [31:0] d1);
    int i;
    @(negedge clk);
    r0_req = 1'b1; r0_addr = 16'h0010;
    r1_req = 1'b1; r1_addr = 16'h0020;
    t0 = -1; t1 = -1; i = 0; d0 = 32'hX; d1 = 32'hX;
    while ((t0 < 0 || t1 < 0) && i < 12) begin
      @(posedge clk); @(negedge clk); i++;
      if (r0_ack) begin t0 = i; d0 = r0_data; r0_req = 1'b0; end
      if (r1_ack) begin t1 = i; d1 = r1_data; r1_req = 1'b0; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
  endtask

  task automatic test_tie;
    int t0, t1, cyc; logic [31:0] d0, d1, d; logic e;
    run_tie(t0, t1, d0, d1);
    n_vec++; if (t0 !== 2) begin n_err++; $display("FAIL tie1_r0_time: got %0d expected 2", t0); end
    n_vec++; if (t1 !== 4) begin n_err++; $display("FAIL tie1_r1_time: got %0d expected 4", t1); end
    n_vec++; if (d0 !== 32'h44332211) begin n_err++; $display("FAIL tie1_r0_data: got %h expected 44332211", d0); end
    n_vec++; if (d1 !== 32'h86878485) begin n_err++; $display("FAIL tie1_r1_data: got %h expected 86878485", d1); end
    do_txn(1'b0, 16'h0030, cyc, d, e);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL tie_mid_latency: got %0d expected 2", cyc); end
    run_tie(t0, t1, d0, d1);
    n_vec++; if (t1 !== 2) begin n_err++; $display("FAIL tie2_r1_time: got %0d expected 2", t1); end
    n_vec++; if (t0 !== 4) begin n_err++; $display("FAIL tie2_r0_time: got %0d expected 4", t0); end
  endtask

  task automatic test_boundary;
    int cyc; logic [31:0] d; logic e;
    do_txn(1'b1, 16'd9996, cyc, d, e);
    n_vec++; if (cyc !== 2) begin n_err++; $display("FAIL bnd9996_latency: got %0d expected 2", cyc); end
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL bnd9996_err: got %b expected 0", e); end
    n_vec++; if (d !== 32'h8D8C8F8E) begin n_err++; $display("FAIL bnd9996_data: got %h expected 8d8c8f8e", d); end
    do_txn(1'b1, 16'd9997, cyc, d, e);
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL bnd9997_err: got %b expected 1", e); end
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL bnd9997_data: got %h expected 0", d); end
    do_txn(1'b1, 16'hFFFE, cyc, d, e);
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL bndfffe_err: got %b expected 1", e); end
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL bndfffe_data: got %h expected 0", d); end
  endtask

  task automatic test_hold;
    int cyc; logic [31:0] d; logic e; logic [15:0] a; logic [31:0] exp_d;
    do_txn(1'b0, 16'h0010, cyc, d, e);
    for (int k = 0; k < 5; k++) begin
      a = 16'h0100 + 16'(k * 4);
      exp_d = {rom_byte(a + 16'd3), rom_byte(a + 16'd2), rom_byte(a + 16'd1), rom_byte(a)};
      do_txn(1'b1, a, cyc, d, e);
      n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL hold_r1_data%0d: got %h expected %h", k, d, exp_d); end
      n_vec++; if ({r0_err, r0_data} !== {1'b0, 32'h44332211}) begin
        n_err++; $display("FAIL hold_r0_%0d: got err=%b data=%h expected err=0 data=44332211", k, r0_err, r0_data);
      end
    end
  endtask

  task automatic test_reset_midop;
    int i, t0; logic seen;
    @(negedge clk);
    r0_req = 1'b1; r0_addr = 16'h0010;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_vec++; if ({r0_ack, r1_ack, r0_err, r1_err} !== 4'b0000) begin n_err++; $display("FAIL midop_flags: got %b expected 0000", {r0_ack, r1_ack, r0_err, r1_err}); end
    n_vec++; if ({r0_data, r1_data, rom_addr} !== 80'd0) begin n_err++; $display("FAIL midop_regs: got %h expected 0", {r0_data, r1_data, rom_addr}); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen = seen | r0_ack; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midop_no_ack: got %b expected 0", seen); end
    rst = 1'b1;
    t0 = -1; i = 0;
    while (t0 < 0 && i < 10) begin
      @(posedge clk); @(negedge clk); i++;
      if (r0_ack) t0 = i;
    end
    n_vec++; if (t0 !== 2) begin n_err++; $display("FAIL midop_rearb_time: got %0d expected 2", t0); end
    n_vec++; if (r0_data !== 32'h44332211) begin n_err++; $display("FAIL midop_rearb_data: got %h expected 44332211", r0_data); end
    r0_req = 1'b0;
  endtask

  task automatic test_starvation;
    int w0, w1, maxw, nack, last;
    @(negedge clk);
    r0_req = 1'b1; r0_addr = 16'h0040;
    r1_req = 1'b1; r1_addr = 16'h0050;
    w0 = 0; w1 = 0; maxw = 0; nack = 0; last = -1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); @(negedge clk);
      w0++; w1++;
      n_vec++; if (r0_ack && r1_ack) begin n_err++; $display("FAIL starve_both_ack: cycle %0d got 11 expected one-hot", c); end
      if (r0_ack || r1_ack) begin
        if (last >= 0) begin
          n_vec++; if (int'(r1_ack) === last) begin n_err++; $display("FAIL starve_alternate: cycle %0d got r%0d again expected r%0d", c, last, 1 - last); end
        end
        last = int'(r1_ack);
        nack++;
      end
      if (r0_ack) w0 = 0;
      if (r1_ack) w1 = 0;
      if (w0 > maxw) maxw = w0;
      if (w1 > maxw) maxw = w1;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    n_vec++; if (maxw > 6) begin n_err++; $display("FAIL starve_max_wait: got %0d expected <= 6", maxw); end
    n_vec++; if (nack !== 25) begin n_err++; $display("FAIL starve_ack_count: got %0d expected 25", nack); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset;
    test_tie;
    test_single;
    test_boundary;
    test_hold;
    test_reset_midop;
    test_starvation;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/oc8051_cxrom_arb.md
OC8051_CXROM_ARB -- requirements
Module: oc8051_cxrom_arb

Interface
REQ-001 Parameter ROM_SIZE, default 10000, meaning ROM depth in bytes; valid fetch window is addr <= ROM_SIZE-4.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port r0_req  input  1  CPU fetch request; held high until r0_ack.
REQ-005 Port r0_addr  input  16  CPU byte address; stable while r0_req is high.
REQ-006 Port r0_ack  output  1  one-cycle completion pulse to requester 0.
REQ-007 Port r0_data  output  32  {byte addr+3, addr+2, addr+1, addr}; valid with r0_ack and held until the next r0_ack.
REQ-008 Port r0_err  output  1  out-of-window flag; valid with r0_ack and held until the next r0_ack.
REQ-009 Ports r1_req, r1_addr, r1_ack, r1_data, r1_err have the same directions, widths and meanings for requester 1 (debug/loader port).
REQ-010 Port rom_addr  output  16  registered address driven to the combinational ROM.
REQ-011 Port rom_data  input  32  ROM read data, combinational from rom_addr.

Function
REQ-012 The FSM SHALL have states IDLE, FETCH and RESP.
REQ-013 In IDLE with any req high, the block SHALL grant one requester, latch its address into rom_addr and its id into gnt_q, and enter FETCH.
REQ-014 On simultaneous requests, the block SHALL grant the requester not recorded in last_gnt (round-robin); with one request, it SHALL grant that requester; last_gnt SHALL update on every grant.
REQ-015 In FETCH, the block SHALL capture rom_data (or 0 if error) and the error flag into the granted requester's data/err registers, and enter RESP.
REQ-016 In RESP, the block SHALL assert the granted requester's ack for exactly one cycle.
REQ-017 Latency: a req sampled high in IDLE SHALL give ack two cycles later (grant edge, capture edge, ack visible in the following cycle).
REQ-018 In RESP, the block SHALL ignore the req of the requester being acked (it is still high from the old transaction).
REQ-019 In RESP, if the other requester's req is high, the block SHALL grant it and go to FETCH; otherwise it SHALL go to IDLE.
REQ-020 Error condition: rom_addr > ROM_SIZE-4, including 16-bit wrap of addr+3; this SHALL set err=1 and data=32'h0, never X.
REQ-021 rom_addr SHALL hold its last value when not granting; the ROM has no enable.
REQ-022 The data/err registers of the non-granted requester SHALL never change.
REQ-023 Starvation bound: a continuously asserted req SHALL be acked within 6 cycles.

Reset
REQ-024 On rst=0, the block SHALL immediately force state=IDLE, r0_ack=r1_ack=0, r0_data=r1_data=0, r0_err=r1_err=0, rom_addr=0, gnt_q=0, last_gnt=1 (requester 0 wins the first tie).
REQ-025 Reset mid-transaction SHALL abort it with no ack; requests still high after rst rises SHALL be re-arbitrated from IDLE.

Structure
REQ-026 Package oc8051_cxrom_arb_pkg SHALL hold the state enum, the default ROM_SIZE constant and the requester-id width.
REQ-027 The two-way round-robin pick (req[1:0], last_gnt -> grant id, valid) SHALL be sub-module oc8051_rr_pick2; all other logic SHALL live in the top level.

Verification
REQ-028 Single request: r0_req=1, r0_addr=16'h0010, ROM bytes 0x10..0x13 = 11,22,33,44 -> r0_ack pulses 2 cycles later with r0_data=32'h44332211 and r0_err=0.
REQ-029 Tie after reset: r0_req=r1_req=1 in the same cycle -> r0 acked first, r1 acked 2 cycles later (back-to-back through RESP->FETCH); order alternates on the next tie.
REQ-030 Boundary: r1_addr=9996 -> err=0 with valid data; r1_addr=9997 -> r1_err=1 and r1_data=0; r1_addr=16'hFFFE -> r1_err=1.
REQ-031 Hold: after an r0 transaction, run 5 r1 transactions -> r0_data and r0_err are unchanged throughout.
REQ-032 Reset mid-op: assert rst=0 during FETCH -> no ack and all outputs 0 asynchronously; with r0_req held, release rst -> r0 acked 2 cycles after the first IDLE cycle.
REQ-033 Starvation: both reqs held high continuously for 50 cycles -> acks strictly alternate and no requester waits more than 6 cycles.
